gclk_sample_monitor: RTL and testbench

- Synthesizable RTL counterpart of the global-clocking sampled-value functions ($past_gclk, $stable_gclk, $changed_gclk, $rose_gclk, $fell_gclk).
- Samples a bus every clk edge and produces per-cycle stability and edge flags, with a past-valid guard for the cycle-0 corner case.
- Tracks run length of stable cycles and flags pulses shorter than a minimum hold window.
- Sits beside the DUT in assertion testbenches; also usable as an on-chip glitch/hold-time monitor.

---
 rtl/gclk_sample_monitor.sv | 123 ++++++++++++
 tb/tb_gclk_sample_monitor.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/gclk_sample_monitor.sv
// Global-clock sampled-value monitor: past/stable/changed/rose/fell flags plus hold-window checking.
// Define GCLK_MON_SVA_EN to compile the embedded concurrent assertions and cover property.
module gclk_sample_monitor #(
  parameter int WIDTH      = 1,
  parameter int MIN_STABLE = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] past_sig,
  output logic             past_valid,
  output logic             stable,
  output logic             changed,
  output logic             rose,
  output logic             fell,
  output logic [CNT_W-1:0] stable_cnt,
  output logic             violation,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam logic [1:0]       ST_EMPTY  = 2'd0;
  localparam logic [1:0]       ST_PRIMED = 2'd1;
  localparam logic [1:0]       ST_TRACK  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_STABLE);

  logic [1:0]       state_r;
  logic             same_s;
  logic             short_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] viol_inc_s;

  // Zero-latency flags against the last enabled sample, plus saturating increments.
  always_comb begin
    same_s     = (sig == past_sig);
    stable     = en && past_valid && same_s;
    changed    = en && past_valid && !same_s;
    rose       = en && past_valid && !past_sig[0] && sig[0];
    fell       = en && past_valid && past_sig[0] && !sig[0];
    // With MIN_STABLE=1 a run of any length is long enough, even after a clear zeroed the count.
    short_s    = (MIN_STABLE > 1) && (stable_cnt < MIN_CNT);
    cnt_inc_s  = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_ONE;
    viol_inc_s = (viol_cnt == CNT_MAX) ? viol_cnt : viol_cnt + CNT_ONE;
  end

  // Sampling FSM, run-length and violation bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_EMPTY;
      past_sig   <= {WIDTH{1'b0}};
      past_valid <= 1'b0;
      stable_cnt <= CNT_ZERO;
      violation  <= 1'b0;
      viol_cnt   <= CNT_ZERO;
    end else begin
      if (en) begin
        past_sig   <= sig;
        past_valid <= 1'b1;
        case (state_r)
          ST_EMPTY: begin
            state_r    <= ST_PRIMED;
            stable_cnt <= CNT_ONE;
          end
          ST_PRIMED: begin
            // No earlier change point exists, so this change cannot be a short pulse.
            if (!same_s) begin
              state_r    <= ST_TRACK;
              stable_cnt <= CNT_ONE;
            end else begin
              stable_cnt <= cnt_inc_s;
            end
          end
          ST_TRACK: begin
            if (!same_s) begin
              stable_cnt <= CNT_ONE;
              if (short_s) begin
                violation <= 1'b1;
                viol_cnt  <= viol_inc_s;
              end else begin
                viol_cnt  <= viol_cnt;
              end
            end else begin
              stable_cnt <= cnt_inc_s;
            end
          end
          default: begin
            state_r    <= ST_EMPTY;
            past_valid <= 1'b0;
            stable_cnt <= CNT_ZERO;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
      // Clear overrides any same-cycle event; a same-cycle change still starts a new run.
      if (clear) begin
        violation  <= 1'b0;
        viol_cnt   <= CNT_ZERO;
        stable_cnt <= changed ? CNT_ONE : CNT_ZERO;
      end else begin
        violation  <= violation | (en && (state_r == ST_TRACK) && !same_s && short_s);
      end
    end
  end

`ifdef GCLK_MON_SVA_EN
  a_stable_not_changed: assert property (@(posedge clk) disable iff (!rst_n)
    (past_valid && en) |-> (stable == !changed));
  a_rose_fell_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(rose && fell));
  a_past_tracks_sig: assert property (@(posedge clk) disable iff (!rst_n)
    en |=> (past_sig == $past(sig)));
  a_violation_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    $fell(violation) |-> $past(clear));
  c_violation: cover property (@(posedge clk) disable iff (!rst_n) violation);
`endif

endmodule

// File: tb/tb_gclk_sample_monitor.sv
// Directed self-checking bench for gclk_sample_monitor (default instance plus a CNT_W=3 instance).
module tb_gclk_sample_monitor;

  logic       clk = 1'b0;
  logic       rst_n, en, clear;
  logic [0:0] sig;
  logic [0:0] m_past_sig, s_past_sig;
  logic       m_pv, m_stable, m_changed, m_rose, m_fell, m_viol;
  logic       s_pv, s_stable, s_changed, s_rose, s_fell, s_viol;
  logic [7:0] m_cnt, m_vcnt;
  logic [2:0] s_cnt, s_vcnt;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  gclk_sample_monitor #(.WIDTH(1), .MIN_STABLE(2), .CNT_W(8)) u_main (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .sig(sig),
    .past_sig(m_past_sig), .past_valid(m_pv), .stable(m_stable), .changed(m_changed),
    .rose(m_rose), .fell(m_fell), .stable_cnt(m_cnt), .violation(m_viol), .viol_cnt(m_vcnt));

  gclk_sample_monitor #(.WIDTH(1), .MIN_STABLE(2), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .sig(sig),
    .past_sig(s_past_sig), .past_valid(s_pv), .stable(s_stable), .changed(s_changed),
    .rose(s_rose), .fell(s_fell), .stable_cnt(s_cnt), .violation(s_viol), .viol_cnt(s_vcnt));

  // {past_valid, stable, changed, rose, fell}
  wire [4:0] m_flags = {m_pv, m_stable, m_changed, m_rose, m_fell};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; sig = 1'b0;
    #12;
    check("reset_flags", {27'd0, m_flags}, 32'd0);
    check("reset_regs", {m_past_sig, m_cnt, m_viol, m_vcnt}, 32'd0);
    rst_n = 1'b1;

    // Constant 0 for five samples
    en = 1'b1; sig = 1'b0; #1;
    check("first_sample_flags", {27'd0, m_flags}, 32'b00000);
    step();
    check("prime_cnt", {24'd0, m_cnt}, 32'd1);
    check("prime_pv", {31'd0, m_pv}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check("hold0_flags", {27'd0, m_flags}, 32'b11000);
      step();
      check("hold0_cnt", {24'd0, m_cnt}, k + 1);
    end
    check("hold0_viol", {31'd0, m_viol}, 32'd0);

    // Rising edge out of PRIMED: no violation, run restarts
    sig = 1'b1; #1;
    check("rise_flags", {27'd0, m_flags}, 32'b10110);
    step();
    check("rise_cnt", {24'd0, m_cnt}, 32'd1);
    check("rise_viol", {31'd0, m_viol}, 32'd0);
    check("hold1_flags", {27'd0, m_flags}, 32'b11000);
    step();
    step();
    check("hold1_cnt", {24'd0, m_cnt}, 32'd3);
    sig = 1'b0; #1;
    check("fall_flags", {27'd0, m_flags}, 32'b10101);
    step();
    check("fall_cnt", {24'd0, m_cnt}, 32'd1);
    check("fall_viol", {31'd0, m_viol}, 32'd0);

    // One-cycle pulse after a 2-cycle run violates
    step();
    check("pre_pulse_cnt", {24'd0, m_cnt}, 32'd2);
    sig = 1'b1; step();
    check("pulse_rise_viol", {31'd0, m_viol}, 32'd0);
    sig = 1'b0; step();
    check("pulse1_viol", {31'd0, m_viol}, 32'd1);
    check("pulse1_vcnt", {24'd0, m_vcnt}, 32'd1);
    check("pulse1_cnt", {24'd0, m_cnt}, 32'd1);
    // Two-cycle pulse does not
    step();
    sig = 1'b1; step(); step();
    sig = 1'b0; step();
    check("pulse2_vcnt", {24'd0, m_vcnt}, 32'd1);
    check("pulse2_viol", {31'd0, m_viol}, 32'd1);
    check("pulse2_cnt", {24'd0, m_cnt}, 32'd1);

    // Disable while sig wiggles, re-enable at old value
    step();
    check("pre_dis_cnt", {24'd0, m_cnt}, 32'd2);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sig = (k % 2 == 0) ? 1'b1 : 1'b0; #1;
      check("dis_flags", {27'd0, m_flags}, 32'b10000);
      step();
      check("dis_cnt", {24'd0, m_cnt}, 32'd2);
      check("dis_past", {31'd0, m_past_sig}, 32'd0);
    end
    en = 1'b1; sig = 1'b0; #1;
    check("reen_flags", {27'd0, m_flags}, 32'b11000);
    step();
    check("reen_cnt", {24'd0, m_cnt}, 32'd3);

    // Saturation: 12 more stable samples
    for (int k = 0; k < 12; k++) step();
    check("main_cnt15", {24'd0, m_cnt}, 32'd15);
    check("sat_cnt7", {29'd0, s_cnt}, 32'd7);
    check("sat_vcnt", {29'd0, s_vcnt}, 32'd1);
    clear = 1'b1; step(); clear = 1'b0;
    check("clr_cnt", {24'd0, m_cnt}, 32'd0);
    check("clr_viol", {31'd0, m_viol}, 32'd0);
    check("clr_vcnt", {24'd0, m_vcnt}, 32'd0);
    check("sat_clr", {s_cnt, s_viol, s_vcnt}, 32'd0);

    // Clear together with a change loads 1
    sig = 1'b1; clear = 1'b1; step(); clear = 1'b0;
    check("clr_chg_cnt", {24'd0, m_cnt}, 32'd1);
    check("clr_chg_viol", {31'd0, m_viol}, 32'd0);
    sig = 1'b0; step();
    check("track_viol", {31'd0, m_viol}, 32'd1);
    check("track_vcnt", {24'd0, m_vcnt}, 32'd1);

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0; #1;
    check("async_rst", {m_past_sig, m_pv, m_cnt, m_viol, m_vcnt}, 32'd0);
    step();
    rst_n = 1'b1; sig = 1'b0; #1;
    check("post_rst_flags", {27'd0, m_flags}, 32'b00000);
    step();
    check("post_rst_cnt", {24'd0, m_cnt}, 32'd1);
    sig = 1'b1; #1;
    check("post_rst_rise", {27'd0, m_flags}, 32'b10110);
    step();
    check("primed_no_viol", {31'd0, m_viol}, 32'd0);
    sig = 1'b0; step();
    check("track_after_rst_viol", {31'd0, m_viol}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
